// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, constants and helpers for the two-master RAM arbiter
package mem_arb_pkg;

  typedef logic master_id_t;
  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  typedef enum logic {IDLE, RD_RET} arb_state_t;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// rtl/mem_arb_rr_pick.sv - round-robin grant with bounded hold; holdbreak_o only with MEM_ARB_STATS_EN
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_i,
  input  logic       req1_i,
  output logic       gnt_valid_o,
  output master_id_t gnt_id_o
`ifdef MEM_ARB_STATS_EN
  ,
  output logic       holdbreak_o
`endif
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  master_id_t ptr_q, ptr_d;
  master_id_t last_q, last_d;
  logic [3:0] hold_q, hold_d;
  logic       both;
  logic       force_sw;

  always_comb begin
    both        = req0_i & req1_i;
    force_sw    = both & (hold_q == HOLD_MAX);
    gnt_valid_o = (req0_i | req1_i) & ~reset;
    gnt_id_o    = M0;
    if (both) begin
      // hold_q counts back-to-back grants to last_q, so a forced switch leaves last_q
      gnt_id_o = force_sw ? ~last_q : ptr_q;
    end else if (req1_i) begin
      gnt_id_o = M1;
    end

    ptr_d  = ptr_q;
    last_d = last_q;
    hold_d = '0;
    if (gnt_valid_o) begin
      last_d = gnt_id_o;
      if (both) begin
        ptr_d = ~gnt_id_o;
        if (gnt_id_o != last_q)
          hold_d = 4'd1;
        else
          hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 4'd1;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  assign holdbreak_o = force_sw & gnt_valid_o;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= M0;
      last_q <= M0;
      hold_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      last_q <= last_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/mem_arbiter_2m.sv
// rtl/mem_arbiter_2m.sv - two-master single-port RAM arbiter; optional counters via MEM_ARB_STATS_EN
module mem_arbiter_2m
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BE_W     = DATA_W / 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic              stat_clear,
  output logic [15:0]       stat_grant0,
  output logic [15:0]       stat_grant1,
  output logic [15:0]       stat_conflict,
  output logic [15:0]       stat_holdbreak
`endif
);

  logic       req0, req1;
  logic       gnt_valid;
  master_id_t gnt_id;
  master_id_t sel, sel_q;
  logic       rd_gnt;
  arb_state_t state_q, state_d;
  master_id_t rd_id_q, rd_id_d;
  logic       rdv0, rdv1;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef MEM_ARB_STATS_EN
  logic holdbreak;
`endif

  mem_arb_rr_pick #(.MAX_HOLD(MAX_HOLD)) u_pick (
    .clk         (clk),
    .reset       (reset),
    .req0_i      (req0),
    .req1_i      (req1),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
`ifdef MEM_ARB_STATS_EN
    ,
    .holdbreak_o (holdbreak)
`endif
  );

  assign m0_waitrequest = ~(req0 & gnt_valid & (gnt_id == M0));
  assign m1_waitrequest = ~(req1 & gnt_valid & (gnt_id == M1));

  // idle cycles keep steering from the last granted master so mem_address stays put
  assign sel            = gnt_valid ? gnt_id : sel_q;
  assign mem_address    = (sel == M1) ? m1_address    : m0_address;
  assign mem_byteenable = (sel == M1) ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = (sel == M1) ? m1_writedata  : m0_writedata;
  assign mem_chipselect = gnt_valid;
  assign mem_write      = gnt_valid & ((sel == M1) ? m1_write : m0_write);
  assign mem_clken      = ~reset;
  assign rd_gnt         = gnt_valid & ((sel == M1) ? (m1_read & ~m1_write) : (m0_read & ~m0_write));

  always_comb begin
    state_d = IDLE;
    rd_id_d = rd_id_q;
    if (rd_gnt) rd_id_d = gnt_id;
    case (state_q)
      IDLE:    state_d = rd_gnt ? RD_RET : IDLE;
      RD_RET:  state_d = rd_gnt ? RD_RET : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // gating with reset drops a return that was in flight when reset arrived
  assign rdv0 = (state_q == RD_RET) & (rd_id_q == M0) & ~reset;
  assign rdv1 = (state_q == RD_RET) & (rd_id_q == M1) & ~reset;

  assign m0_readdatavalid = rdv0;
  assign m1_readdatavalid = rdv1;
  assign m0_readdata      = reset ? '0 : (rdv0 ? mem_readdata : rdata0_q);
  assign m1_readdata      = reset ? '0 : (rdv1 ? mem_readdata : rdata1_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_id_q  <= M0;
      sel_q    <= M0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      rd_id_q <= rd_id_d;
      if (gnt_valid) sel_q <= gnt_id;
      if (rdv0) rdata0_q <= mem_readdata;
      if (rdv1) rdata1_q <= mem_readdata;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] grant0_q, grant1_q, conflict_q, holdbreak_q;

  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      grant0_q    <= '0;
      grant1_q    <= '0;
      conflict_q  <= '0;
      holdbreak_q <= '0;
    end else begin
      grant0_q    <= sat_inc16(grant0_q, gnt_valid & (gnt_id == M0));
      grant1_q    <= sat_inc16(grant1_q, gnt_valid & (gnt_id == M1));
      conflict_q  <= sat_inc16(conflict_q, req0 & req1);
      holdbreak_q <= sat_inc16(holdbreak_q, holdbreak);
    end
  end

  assign stat_grant0    = grant0_q;
  assign stat_grant1    = grant1_q;
  assign stat_conflict  = conflict_q;
  assign stat_holdbreak = holdbreak_q;
`endif

endmodule

// File: tb/tb_mem_arbiter_2m.sv
// tb/tb_mem_arbiter_2m.sv - directed scoreboard bench for mem_arbiter_2m (MEM_ARB_STATS_EN aware)
module tb_mem_arbiter_2m;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic [BW-1:0] m0_byteenable = '0, m1_byteenable = '0;
  logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;
`ifdef MEM_ARB_STATS_EN
  logic          stat_clear = 1'b0;
  logic [15:0]   stat_grant0, stat_grant1, stat_conflict, stat_holdbreak;
`endif

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];

  logic [31:0] model [0:(1<<AW)-1];
  logic [31:0] ram   [0:(1<<AW)-1];
  logic [31:0] ram_rd = '0;

  always #5 clk = ~clk;

  mem_arbiter_2m dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_clear       (stat_clear),
    .stat_grant0      (stat_grant0),
    .stat_grant1      (stat_grant1),
    .stat_conflict    (stat_conflict),
    .stat_holdbreak   (stat_holdbreak)
`endif
  );

  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // single-port RAM: registered address, one-cycle read
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] <= be_merge(ram[mem_address], mem_writedata, mem_byteenable);
      else ram_rd <= ram[mem_address];
    end
  end
  assign mem_readdata = ram_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input int exp_id);
    chk({tag, "_wait0"}, 32'(m0_waitrequest), (exp_id == 0) ? 32'd0 : 32'd1);
    chk({tag, "_wait1"}, 32'(m1_waitrequest), (exp_id == 1) ? 32'd0 : 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0;
    m1_read = 1'b0; m1_write = 1'b0;
  endtask

  // scoreboard: push on accepted read, pop one cycle later
  always @(negedge clk) begin
    sb_t e;
    if (reset) begin
      chk("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
      chk("rst_rdv1", 32'(m1_readdatavalid), 32'd0);
      sb.delete();
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.id == 1'b0) begin
          chk("sb_rdv0", 32'(m0_readdatavalid), 32'd1);
          chk("sb_rdata0", m0_readdata, e.data);
          chk("sb_quiet1", 32'(m1_readdatavalid), 32'd0);
        end else begin
          chk("sb_rdv1", 32'(m1_readdatavalid), 32'd1);
          chk("sb_rdata1", m1_readdata, e.data);
          chk("sb_quiet0", 32'(m0_readdatavalid), 32'd0);
        end
      end else begin
        chk("no_rdv0", 32'(m0_readdatavalid), 32'd0);
        chk("no_rdv1", 32'(m1_readdatavalid), 32'd0);
      end
      if (!m0_waitrequest) begin
        if (m0_write) model[m0_address] = be_merge(model[m0_address], m0_writedata, m0_byteenable);
        else if (m0_read) begin e.id = 1'b0; e.data = model[m0_address]; sb.push_back(e); end
      end
      if (!m1_waitrequest) begin
        if (m1_write) model[m1_address] = be_merge(model[m1_address], m1_writedata, m1_byteenable);
        else if (m1_read) begin e.id = 1'b1; e.data = model[m1_address]; sb.push_back(e); end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      model[i] = '0;
      ram[i] = '0;
    end

    // reset with a pending request: nothing may be granted
    m0_read = 1'b1;
    @(negedge clk);
    chk("rst_wait0", 32'(m0_waitrequest), 32'd1);
    chk("rst_cs", 32'(mem_chipselect), 32'd0);
    chk("rst_clken", 32'(mem_clken), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    m0_read = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk_grant("post_rst", -1);
    chk("post_rst_cs", 32'(mem_chipselect), 32'd0);
    chk("post_rst_wr", 32'(mem_write), 32'd0);
    chk("post_rst_clken", 32'(mem_clken), 32'd1);
    chk("post_rst_rd0", m0_readdata, 32'd0);
    chk("post_rst_rd1", m1_readdata, 32'd0);
`ifdef MEM_ARB_STATS_EN
    chk("post_rst_conf", 32'(stat_conflict), 32'd0);
    chk("post_rst_g0", 32'(stat_grant0), 32'd0);
`endif

    // m0 writes, m1 reads back
    step();
    m0_address = 13'h0010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF; m0_write = 1'b1;
    @(negedge clk);
    chk_grant("w0", 0);
    chk("w0_memwr", 32'(mem_write), 32'd1);
    chk("w0_addr", 32'(mem_address), 32'h10);
    chk("w0_wdata", mem_writedata, 32'hDEADBEEF);
    step();
    idle();
    m1_address = 13'h0010; m1_read = 1'b1;
    @(negedge clk);
    chk_grant("r1", 1);
    chk("r1_memwr", 32'(mem_write), 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("r1_rdv1", 32'(m1_readdatavalid), 32'd1);
    chk("r1_rdata1", m1_readdata, 32'hDEADBEEF);
    chk("r1_rdv0", 32'(m0_readdatavalid), 32'd0);
    chk("idle_cs", 32'(mem_chipselect), 32'd0);
    chk("idle_addr_hold", 32'(mem_address), 32'h10);

    // partial byte-enable write by m1, read by m0; m1_readdata must hold
    step();
    m1_writedata = 32'h11223344; m1_byteenable = 4'h3; m1_write = 1'b1;
    @(negedge clk);
    chk_grant("w1be", 1);
    step();
    idle();
    m0_address = 13'h0010; m0_read = 1'b1;
    @(negedge clk);
    chk_grant("r0be", 0);
    step();
    idle();
    @(negedge clk);
    chk("r0be_rdata0", m0_readdata, 32'hDEAD3344);
    chk("r0be_hold1", m1_readdata, 32'hDEADBEEF);

    // read+write together acts as a write with no data return
    step();
    m0_address = 13'h0030; m0_writedata = 32'hCAFEF00D; m0_byteenable = 4'hF;
    m0_read = 1'b1; m0_write = 1'b1;
    @(negedge clk);
    chk("rw_memwr", 32'(mem_write), 32'd1);
    step();
    idle();
    m1_address = 13'h0030; m1_read = 1'b1;
    @(negedge clk);
    chk("rw_rdv0", 32'(m0_readdatavalid), 32'd0);
    step();
    idle();
    @(negedge clk);
    chk("rw_rdata1", m1_readdata, 32'hCAFEF00D);

    // preload two tables
    for (int i = 0; i < 8; i++) begin
      step();
      m0_address = 13'(32'h40 + i); m0_writedata = 32'hA5000000 + i; m0_byteenable = 4'hF; m0_write = 1'b1;
      @(negedge clk);
      chk_grant("pre0", 0);
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      step();
      m1_address = 13'(32'h80 + i); m1_writedata = 32'h5A000000 + i; m1_byteenable = 4'hF; m1_write = 1'b1;
      @(negedge clk);
      chk_grant("pre1", 1);
    end
    step();
    idle();

    // continuous contention: strict alternation starting at m0
    for (int k = 0; k < 8; k++) begin
      step();
      m0_address = 13'(32'h40 + k); m0_read = 1'b1;
      m1_address = 13'(32'h80 + k); m1_read = 1'b1;
      @(negedge clk);
      chk_grant("rr", k % 2);
    end
    step();
    idle();

    // m0 streams; m1 joins for cycles 3..10
    for (int c = 0; c < 14; c++) begin
      step();
      m0_address = 13'(32'h40 + (c % 8)); m0_read = 1'b1;
      m1_address = 13'(32'h80 + (c % 8)); m1_read = (c >= 3 && c <= 10);
      @(negedge clk);
      chk_grant("join", (c >= 3 && c <= 10 && (c % 2) == 0) ? 1 : 0);
    end
    step();
    idle();

    // reset right after a read grant to m1
    step();
    m1_address = 13'h0081; m1_read = 1'b1;
    @(negedge clk);
    chk_grant("rst_mid", 1);
    step();
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_rdv1_n1", 32'(m1_readdatavalid), 32'd0);
    step();
    @(negedge clk);
    chk("rst_mid_rdv1_n2", 32'(m1_readdatavalid), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_rdv1_n3", 32'(m1_readdatavalid), 32'd0);
    step();
    m0_address = 13'h0041; m0_read = 1'b1;
    @(negedge clk);
    chk_grant("post_mid", 0);
    step();
    idle();
    @(negedge clk);
    chk("post_mid_rdata0", m0_readdata, 32'hA5000001);

`ifdef MEM_ARB_STATS_EN
    step();
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    m0_address = 13'h0042; m0_read = 1'b1;
    m1_address = 13'h0082; m1_read = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk("stat_conflict", 32'(stat_conflict), 32'd20);
    chk("stat_grant0", 32'(stat_grant0), 32'd10);
    chk("stat_grant1", 32'(stat_grant1), 32'd10);
    chk("stat_holdbreak", 32'(stat_holdbreak), 32'd0);
    step();
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    @(negedge clk);
    chk("clr_conflict", 32'(stat_conflict), 32'd0);
    chk("clr_grant0", 32'(stat_grant0), 32'd0);
    chk("clr_grant1", 32'(stat_grant1), 32'd0);
`endif

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_2m.md
Name: mem_arbiter_2m

Overview:
- Two-master arbiter sharing the single-port 32-bit on-chip RAM: 13-bit word address, byte enables, registered address, 1-cycle read latency.
- Requesters are the CPU data master (m0) and the quadrature-decoder sample logger (m1).
- Accepts at most one access per cycle, steers it to the RAM, and returns read data to the issuing master.
- Uses round-robin priority with a bounded-hold rule.

Parameters:
- ADDR_W, 13, word address width.
- DATA_W, 32, data width.
- BE_W, DATA_W/8, byte-enable width.
- MAX_HOLD, 4, maximum consecutive grants to one master while the other waits (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_address  in  ADDR_W  m0 word address
- m0_byteenable  in  BE_W  m0 byte lanes
- m0_read  in  1  m0 read request
- m0_write  in  1  m0 write request
- m0_writedata  in  DATA_W  m0 write data
- m0_waitrequest  out  1  m0 stall; the request is accepted in the cycle this is low
- m0_readdata  out  DATA_W  m0 read data
- m0_readdatavalid  out  1  m0 read data valid
- m1_*  same set and meaning as m0_*
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  BE_W  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  from RAM, valid 1 cycle after a read is issued

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Values during and after reset:
  - m*_waitrequest = 1.
  - m*_readdatavalid = 0.
  - m*_readdata = 0.
  - mem_chipselect = 0, mem_write = 0.
  - Priority pointer = m0.
  - Hold counter = 0.
  - mem_clken = 1 always, except 0 while reset is high.
- Request definition: reqN = mN_read | mN_write.
  - If read and write are both high, it is treated as a write; read data is not returned.
- Grant decision is combinational, every cycle:
  - Only one requester: that requester is granted.
  - Both requesting: the master at the priority pointer is granted, unless hold_cnt == MAX_HOLD, in which case the other master is granted.
  - mN_waitrequest = ~(reqN & grantN).
- RAM drive: the granted master's address, byteenable and writedata are muxed to mem_*.
  - mem_chipselect = any grant.
  - mem_write = granted master's write.
  - With no grant: mem_chipselect = 0 and mem_address holds its last value (registered mux select).
- Priority pointer (updated on a granted cycle):
  - Both requesting: pointer moves to the non-granted master.
  - Only one requesting: pointer unchanged.
- Hold counter:
  - Increments when the same master is granted again while the other is requesting.
  - Resets to 1 on a switch of grant.
  - Resets to 0 when the other is not requesting.
  - Saturates at MAX_HOLD.
- Read return:
  - rd_pend and rd_id are registered on the cycle a read is granted.
  - Next cycle: m{rd_id}_readdatavalid = 1 and m{rd_id}_readdata = mem_readdata.
  - The other master's readdatavalid = 0 and its readdata holds its last value.
- Throughput and latency:
  - Back-to-back reads are fully pipelined: 1 access/cycle, read latency 1.
  - A write followed by a read of the same address returns the new data (RAM write completes in its cycle).
- Reset mid-read: a pending readdatavalid is dropped; no stale valid after reset deasserts.
- State machine:
  - IDLE: no pending read.
  - RD_RET: a read was issued last cycle.
  - IDLE→RD_RET on read grant.
  - RD_RET→RD_RET on another read grant, else →IDLE.
  - Any transition →IDLE on reset.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds the following 16-bit saturating counters, cleared by reset:
  - stat_grant0, stat_grant1: grants per master.
  - stat_conflict: cycles with both requesting.
  - stat_holdbreak: forced switches from MAX_HOLD.
  - stat_clear input (1 bit): synchronous clear of all counters.
- When not defined: no counters and no stat_* ports; the arbitration path is unchanged.

Decomposition:
- Package mem_arb_pkg:
  - typedef master_id_t (1 bit), constants M0 = 0 and M1 = 1.
  - typedef arb_state_t {IDLE, RD_RET}.
  - Default widths ADDR_W_DEF = 13, DATA_W_DEF = 32.
- One sub-module: mem_arb_rr_pick (combinational grant plus pointer/hold-counter registers), instantiated once.
- Muxing and read return stay in the top level.

Test Plan:
- Reset held 3 cycles, then released with no requests → waitrequest = 1/1, readdatavalid = 0, mem_chipselect = 0.
- m0 writes 0xDEADBEEF to 0x0010 with BE = 0xF, then m1 reads 0x0010 → m1_readdatavalid one cycle after its grant with 0xDEADBEEF; m0_readdatavalid stays 0.
- Both read continuously with MAX_HOLD = 4 → grants alternate m0, m1, m0, m1 starting at m0; each readdatavalid is routed to the correct master with latency 1.
- m0 requests continuously; m1 requests only in cycles 3..10 → no master waits more than 1 cycle; m1's first grant occurs by cycle 4.
- Read granted to m1 at cycle N, reset asserted at N+1 → m1_readdatavalid = 0 at N+1 and N+2; clean operation afterwards.
- With MEM_ARB_STATS_EN, 20 cycles of both reading → stat_conflict = 20, stat_grant0 = 10, stat_grant1 = 10; pulsing stat_clear → all counters 0.
